// File: rtl/pe_seq_pkg.sv
// ---------------------------------------------------------------------------
// pe_seq_pkg : shared types and limits for the PE_rco sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] RCO_ROW = 2'b00;
  localparam logic [1:0] RCO_COL = 2'b01;
  localparam logic [1:0] RCO_OUT = 2'b10;

  localparam int ROW_MAX_LEN = 31;
  localparam int OUT_MAX_LEN = 1023;

endpackage

`default_nettype wire

// File: rtl/lst_delay_line.sv
// ---------------------------------------------------------------------------
// lst_delay_line : DEPTH-stage register pipeline, cleared by reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lst_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pe_rco_seq.sv
// ---------------------------------------------------------------------------
// pe_rco_seq : job sequencer feeding one PE_rco processing element
// Option     : PE_SEQ_STALL_CNT_EN adds a saturating RUN-stall counter port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pe_rco_seq
  import pe_seq_pkg::*;
#(
  parameter int INT_BITS = 5,
  parameter int FRC_BITS = 7,
  parameter int ROM_LAT  = 1,
  parameter int MAC_LAT  = 1,
  localparam int W       = INT_BITS + FRC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [1:0]   sel_i,
  input  logic [9:0]   len_i,
  output logic         busy_o,
  output logic         err_o,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         init_o,
  output logic         en_o,
  output logic [4:0]   address_row_o,
  output logic [4:0]   address_col_o,
  output logic [9:0]   address_o_o,
  output logic [1:0]   rco_sel_o,
  output logic [W-1:0] din_o,
  input  logic [W-1:0] pe_dout_i,
  output logic         res_valid_o,
  output logic [W-1:0] res_data_o
`ifdef PE_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt_o
`endif
);

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   sel_q;
  logic [9:0]   len_q;
  logic [9:0]   idx_q;
  logic         err_q;
  logic         res_valid_q;
  logic [W-1:0] res_data_q;

  logic w_legal, w_job_req, w_accept, w_drain_done, w_run;

  assign w_legal = !((sel_i == 2'b11) || (len_i == 10'd0) ||
                     ((sel_i != RCO_OUT) && (len_i > 10'(ROW_MAX_LEN))));
  // The result-beat cycle is already IDLE but still busy, so start is masked there.
  assign w_job_req    = start_i && (state_q == IDLE) && !res_valid_q;
  assign w_run        = (state_q == RUN);
  assign in_ready_o   = w_run && (idx_q < len_q);
  assign w_accept     = in_valid_i && in_ready_o;
  assign w_drain_done = (state_q == DRAIN) && (cnt_q == 8'(ROM_LAT + MAC_LAT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_job_req && w_legal) begin
          state_d = INIT;
          cnt_d   = 8'd0;
        end
      end
      INIT: begin
        if (cnt_q == 8'(ROM_LAT)) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RUN: begin
        if (w_accept && ((idx_q + 10'd1) == len_q)) begin
          state_d = DRAIN;
          cnt_d   = 8'd0;
        end
      end
      DRAIN: begin
        if (w_drain_done) state_d = IDLE;
        else              cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      sel_q       <= 2'b00;
      len_q       <= 10'd0;
      idx_q       <= 10'd0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= w_job_req && !w_legal;
      res_valid_q <= w_drain_done;
      if (w_job_req && w_legal) begin
        sel_q <= sel_i;
        len_q <= len_i;
        idx_q <= 10'd0;
      end else if (w_accept) begin
        idx_q <= idx_q + 10'd1;
      end
      if (w_drain_done) res_data_q <= pe_dout_i;
    end
  end

  // en/din trail the accept by ROM_LAT so they line up with the ROM word.
  lst_delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH (W + 1)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({w_accept, (w_accept ? in_data_i : {W{1'b0}})}),
    .q_o ({en_o, din_o})
  );

  assign busy_o        = (state_q != IDLE) || res_valid_q;
  assign err_o         = err_q;
  assign init_o        = (state_q == INIT);
  assign address_row_o = (w_run && sel_q == RCO_ROW) ? idx_q[4:0] : 5'd0;
  assign address_col_o = (w_run && sel_q == RCO_COL) ? idx_q[4:0] : 5'd0;
  assign address_o_o   = (w_run && sel_q == RCO_OUT) ? idx_q : 10'd0;
  assign rco_sel_o     = sel_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;

`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (w_job_req && w_legal) begin
      stall_cnt_q <= 16'd0;
    end else if (in_ready_o && !in_valid_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_rco_seq.sv
// ---------------------------------------------------------------------------
// tb_pe_rco_seq : job table plus reset/start corner sequences for pe_rco_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pe_rco_seq;

  localparam int INT_BITS = 5;
  localparam int FRC_BITS = 7;
  localparam int ROM_LAT  = 1;
  localparam int MAC_LAT  = 1;
  localparam int W        = INT_BITS + FRC_BITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   sel;
  logic [9:0]   len;
  logic         busy, err;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         init, en;
  logic [4:0]   address_row, address_col;
  logic [9:0]   address_o;
  logic [1:0]   rco_sel;
  logic [W-1:0] din;
  logic [W-1:0] pe_dout;
  logic         res_valid;
  logic [W-1:0] res_data;
`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_rco_seq #(
    .INT_BITS (INT_BITS),
    .FRC_BITS (FRC_BITS),
    .ROM_LAT  (ROM_LAT),
    .MAC_LAT  (MAC_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .sel_i         (sel),
    .len_i         (len),
    .busy_o        (busy),
    .err_o         (err),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_ready_o    (in_ready),
    .init_o        (init),
    .en_o          (en),
    .address_row_o (address_row),
    .address_col_o (address_col),
    .address_o_o   (address_o),
    .rco_sel_o     (rco_sel),
    .din_o         (din),
    .pe_dout_i     (pe_dout),
    .res_valid_o   (res_valid),
    .res_data_o    (res_data)
`ifdef PE_SEQ_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt)
`endif
  );

  typedef struct {
    logic [1:0] sel;
    logic [9:0] len;
    int         gap;      // percent chance of an idle beat
    bit         ramp;     // data 1.0, 2.0, ... instead of random
    bit         exp_err;  // job must be rejected
  } vec_t;

  typedef struct {
    int           due;
    logic [W-1:0] d;
  } pend_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_init"}, init, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_arow"}, address_row, 0);
    chk({tag, "_acol"}, address_col, 0);
    chk({tag, "_aout"}, address_o, 0);
    chk({tag, "_rsel"}, rco_sel, 0);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_rv"}, res_valid, 0);
    chk({tag, "_rd"}, res_data, 0);
  endtask

  task automatic reject(input logic [1:0] s, input logic [9:0] l);
    @(negedge clk);
    start = 1'b1; sel = s; len = l;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_init", init, 0);
    @(negedge clk);
    #1;
    chk("rej_err_pulse", err, 0);
    chk("rej_busy2", busy, 0);
    chk("rej_init2", init, 0);
  endtask

  task automatic run_job(input logic [1:0] s, input logic [9:0] l, input int gap,
                         input bit ramp, input bit poke);
    int           acc, last_acc, stalls, en_seen;
    bit           done, iv, exp_rv;
    logic [W-1:0] cap, d;
    pend_t        pend[$];
    acc = 0; last_acc = -1; stalls = 0; en_seen = 0; done = 0; cap = '0;

    @(negedge clk);
    start = 1'b1; sel = s; len = l; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i <= ROM_LAT; i++) begin
      #1;
      chk("init_hi", init, 1);
      chk("init_rdy", in_ready, 0);
      chk("init_en", en, 0);
      chk("init_busy", busy, 1);
      chk("init_rsel", rco_sel, s);
      @(negedge clk);
    end

    for (int cyc = 0; !done; cyc++) begin
      if (cyc > 4000) begin
        chk("job_timeout", 0, 1);
        break;
      end
      iv = (acc < int'(l)) && ($urandom_range(0, 99) >= gap);
      d  = ramp ? W'((acc + 1) << FRC_BITS) : W'($urandom);
      in_valid = iv;
      in_data  = d;
      pe_dout  = W'($urandom);
      start    = poke && (acc == int'(l));
      #1;
      chk("run_busy", busy, 1);
      chk("run_init", init, 0);
      chk("run_rsel", rco_sel, s);
      chk("run_rdy", in_ready, (acc < int'(l)));
      if (acc < int'(l)) begin
        chk("addr_row", address_row, (s == 2'b00) ? 5'(acc) : 5'd0);
        chk("addr_col", address_col, (s == 2'b01) ? 5'(acc) : 5'd0);
        chk("addr_out", address_o, (s == 2'b10) ? 10'(acc) : 10'd0);
      end
      if (en) en_seen++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        chk("en_hi", en, 1);
        chk("din", din, pend[0].d);
        void'(pend.pop_front());
      end else begin
        chk("en_lo", en, 0);
      end
      if (acc < int'(l)) begin
        if (iv) begin
          pend.push_back('{cyc + ROM_LAT, d});
          acc++;
          if (acc == int'(l)) last_acc = cyc;
        end else begin
          stalls++;
        end
      end
      if (last_acc >= 0 && cyc == last_acc + ROM_LAT + MAC_LAT) cap = pe_dout;
      exp_rv = (last_acc >= 0) && (cyc == last_acc + ROM_LAT + MAC_LAT + 1);
      chk("res_valid", res_valid, exp_rv);
      if (exp_rv) begin
        chk("res_data", res_data, cap);
`ifdef PE_SEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stalls);
`endif
        done = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_busy", busy, 0);
    chk("post_rv", res_valid, 0);
    chk("post_init", init, 0);
    chk("post_rdata_hold", res_data, cap);
    chk("en_count", en_seen, l);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{2'b00, 10'd4,    0, 1, 0};
    tbl[1] = '{2'b01, 10'd31,  20, 0, 0};
    tbl[2] = '{2'b10, 10'd1023, 30, 0, 0};
    tbl[3] = '{2'b11, 10'd5,    0, 0, 1};
    tbl[4] = '{2'b01, 10'd32,   0, 0, 1};
    tbl[5] = '{2'b00, 10'd0,    0, 0, 1};
    tbl[6] = '{2'b10, 10'd0,    0, 0, 1};
    tbl[7] = '{2'b00, 10'd31,  40, 0, 0};
    tbl[8] = '{2'b00, 10'd3,   50, 0, 0};
    tbl[9] = '{2'b10, 10'd1,    0, 0, 0};

    rst = 1'b1; start = 1'b0; sel = 2'b00; len = 10'd0;
    in_valid = 1'b0; in_data = '0; pe_dout = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      if (tbl[k].exp_err) reject(tbl[k].sel, tbl[k].len);
      else run_job(tbl[k].sel, tbl[k].len, tbl[k].gap, tbl[k].ramp, 1'b0);
    end

    // start pulsed through DRAIN and the result beat is ignored
    run_job(2'b01, 10'd6, 25, 1'b0, 1'b1);

    // rst in RUN at idx 2 of 5 aborts cleanly
    @(negedge clk);
    start = 1'b1; sel = 2'b00; len = 10'd5;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = W'($urandom);
    repeat (ROM_LAT + 1) @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    chk("abort_idx2", address_row, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_idle_zero("abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_rv", res_valid, 0);
      chk("abort_idle", busy, 0);
    end
    run_job(2'b00, 10'd5, 10, 1'b0, 1'b0);

    // start together with rst never launches a job
    @(negedge clk);
    rst = 1'b1; start = 1'b1; sel = 2'b10; len = 10'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rststart_busy", busy, 0);
    chk("rststart_init", init, 0);
    @(negedge clk);
    #1;
    chk("rststart_busy2", busy, 0);
    chk("rststart_init2", init, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
